// File: rtl/flood_input_ctrl.sv
// flood_input_ctrl: Flood-It button debounce, palette cursor and game_logic handshakes
// Ports:
//   CLOCK, RESET                       clock, async active-high reset
//   BTN_LEFT/RIGHT/SEL/START           raw asynchronous push-buttons
//   TOP_LEFT_COLOR                     colour of board cell [0][0]
//   CHANGING_COLOR, ACK_BEGIN_GAME     acks from game_logic
//   CURSOR_COLOR, COLOR_SELECTED       highlighted / offered palette colour
//   COLOR_SEL_SIG, BEGIN_GAME          requests to game_logic
//   MOVE_COUNT, BUSY                   completed moves (saturating), non-idle flag
module flood_input_ctrl #(
  parameter int NUM_COLORS      = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_SEL,
  input  logic       BTN_START,
  input  logic [2:0] TOP_LEFT_COLOR,
  input  logic       CHANGING_COLOR,
  input  logic       ACK_BEGIN_GAME,
  output logic [2:0] CURSOR_COLOR,
  output logic [2:0] COLOR_SELECTED,
  output logic       COLOR_SEL_SIG,
  output logic       BEGIN_GAME,
  output logic [7:0] MOVE_COUNT,
  output logic       BUSY
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SEL_REQ, SEL_WAIT, START_REQ, START_WAIT} state_t;
  logic [3:0] raw, sync1_q, sync2_q, deb_q, press_q;
  logic [CW-1:0] cnt_q [4];
  logic left_p, right_p, sel_p, start_p;
  logic [2:0] cursor_q, sel_col_q;
  logic [7:0] moves_q;
  logic sel_sig_q, begin_q, busy_q, pend_q;
  state_t state_q;
  assign raw = {BTN_START, BTN_SEL, BTN_RIGHT, BTN_LEFT};
  assign {start_p, sel_p, right_p, left_p} = press_q;
  // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle;
  // the press pulse is registered at that edge so it lasts exactly one cycle.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == deb_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q[i]   <= '0;
          deb_q[i]   <= sync2_q[i];
          press_q[i] <= sync2_q[i];
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) cursor_q <= '0;
    else if (left_p && !right_p) cursor_q <= (cursor_q == 3'd0) ? 3'(NUM_COLORS - 1) : cursor_q - 3'd1;
    else if (right_p && !left_p) cursor_q <= (cursor_q == 3'(NUM_COLORS - 1)) ? 3'd0 : cursor_q + 3'd1;
  end
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      sel_sig_q <= 1'b0;
      begin_q   <= 1'b0;
      sel_col_q <= '0;
      moves_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (start_p || pend_q) begin
            state_q <= START_REQ;
            begin_q <= 1'b1;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else if (sel_p && cursor_q != TOP_LEFT_COLOR) begin
            state_q   <= SEL_REQ;
            sel_col_q <= cursor_q;
            sel_sig_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        SEL_REQ: begin
          pend_q <= pend_q | start_p;
          if (CHANGING_COLOR) begin
            sel_sig_q <= 1'b0;
            state_q   <= SEL_WAIT;
          end
        end
        SEL_WAIT: begin
          pend_q <= pend_q | start_p;
          if (!CHANGING_COLOR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            moves_q <= (moves_q == 8'hff) ? moves_q : moves_q + 8'd1;
          end
        end
        START_REQ:
          if (ACK_BEGIN_GAME) begin
            begin_q <= 1'b0;
            moves_q <= '0;
            state_q <= START_WAIT;
          end
        START_WAIT:
          if (!ACK_BEGIN_GAME) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign CURSOR_COLOR   = cursor_q;
  assign COLOR_SELECTED = sel_col_q;
  assign COLOR_SEL_SIG  = sel_sig_q;
  assign BEGIN_GAME     = begin_q;
  assign MOVE_COUNT     = moves_q;
  assign BUSY           = busy_q;
endmodule

// File: tb/tb_flood_input_ctrl.sv
// tb_flood_input_ctrl: scoreboard bench for flood_input_ctrl with a game_logic responder model
module tb_flood_input_ctrl;
  localparam logic [3:0] BL = 4'b0001, BR = 4'b0010, BS = 4'b0100, BT = 4'b1000;
  logic clk, RESET, BTN_LEFT, BTN_RIGHT, BTN_SEL, BTN_START;
  logic [2:0] TOP_LEFT_COLOR, CURSOR_COLOR, COLOR_SELECTED;
  logic CHANGING_COLOR, ACK_BEGIN_GAME, COLOR_SEL_SIG, BEGIN_GAME, BUSY;
  logic [7:0] MOVE_COUNT;
  typedef struct {bit st; int col;} req_t;
  req_t exp_q[$];
  req_t me;
  int checks = 0, passes = 0, cyc = 0, n_sel = 0;
  int cur = 0, tl = 1, moves = 0;
  int sel_hold = 3, ack_hold = 2;
  bit resp_en = 1, p_sel = 0, p_beg = 0;
  flood_input_ctrl #(.NUM_COLORS(6), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK(clk), .RESET(RESET), .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT),
    .BTN_SEL(BTN_SEL), .BTN_START(BTN_START), .TOP_LEFT_COLOR(TOP_LEFT_COLOR),
    .CHANGING_COLOR(CHANGING_COLOR), .ACK_BEGIN_GAME(ACK_BEGIN_GAME),
    .CURSOR_COLOR(CURSOR_COLOR), .COLOR_SELECTED(COLOR_SELECTED),
    .COLOR_SEL_SIG(COLOR_SEL_SIG), .BEGIN_GAME(BEGIN_GAME),
    .MOVE_COUNT(MOVE_COUNT), .BUSY(BUSY));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask
  task automatic press(input logic [3:0] m);
    @(posedge clk);
    #2 {BTN_START, BTN_SEL, BTN_RIGHT, BTN_LEFT} = m;
    repeat (10) @(posedge clk);
    #2 {BTN_START, BTN_SEL, BTN_RIGHT, BTN_LEFT} = 4'b0;
    repeat (8) @(posedge clk);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((BUSY || CHANGING_COLOR || ACK_BEGIN_GAME) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
  endtask
  task automatic do_move();
    cur = (cur + 1) % 6;
    press(BR);
    exp_q.push_back('{1'b0, cur});
    press(BS);
    wait_idle();
    moves = (moves == 255) ? 255 : moves + 1;
    tl = cur;
  endtask
  // game_logic model: ack one cycle after a request, release after a hold time
  initial forever begin
    @(negedge clk);
    if (resp_en && COLOR_SEL_SIG && !CHANGING_COLOR) begin
      @(posedge clk);
      #1 CHANGING_COLOR = 1'b1;
      repeat (sel_hold) @(posedge clk);
      #1 TOP_LEFT_COLOR = COLOR_SELECTED;
      CHANGING_COLOR = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (resp_en && BEGIN_GAME && !ACK_BEGIN_GAME) begin
      @(posedge clk);
      #1 ACK_BEGIN_GAME = 1'b1;
      repeat (ack_hold) @(posedge clk);
      #1 ACK_BEGIN_GAME = 1'b0;
    end
  end
  // scoreboard monitor: every request rising edge must match the oldest expected request
  always @(negedge clk) begin
    if (COLOR_SEL_SIG && !p_sel) begin
      n_sel++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_sel: colour %0d with nothing expected", COLOR_SELECTED);
      end else begin
        me = exp_q.pop_front();
        chk("sb_kind_sel", 0, me.st);
        chk("sb_color", COLOR_SELECTED, me.col);
      end
    end
    if (BEGIN_GAME && !p_beg) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_begin: BEGIN_GAME rose with nothing expected");
      end else begin
        me = exp_q.pop_front();
        chk("sb_kind_begin", 1, me.st);
      end
    end
    if (COLOR_SEL_SIG && BEGIN_GAME) begin
      checks++;
      $display("FAIL both_requests: COLOR_SEL_SIG and BEGIN_GAME both 1");
    end
    p_sel = COLOR_SEL_SIG;
    p_beg = BEGIN_GAME;
  end
  initial begin
    int t0, r, n0, n;
    RESET = 1'b1;
    {BTN_START, BTN_SEL, BTN_RIGHT, BTN_LEFT} = 4'b0;
    TOP_LEFT_COLOR = 3'd1;
    CHANGING_COLOR = 1'b0;
    ACK_BEGIN_GAME = 1'b0;
    repeat (3) @(posedge clk);
    #2 RESET = 1'b0;
    @(negedge clk);
    chk("rst_cursor", CURSOR_COLOR, 0);
    chk("rst_selected", COLOR_SELECTED, 0);
    chk("rst_sel_sig", COLOR_SEL_SIG, 0);
    chk("rst_begin", BEGIN_GAME, 0);
    chk("rst_moves", MOVE_COUNT, 0);
    chk("rst_busy", BUSY, 0);
    press(BL);
    chk("wrap_left", CURSOR_COLOR, 5);
    press(BR);
    press(BR);
    chk("wrap_right", CURSOR_COLOR, 1);
    press(BL | BR);
    chk("left_right_same", CURSOR_COLOR, 1);
    press(BR);
    press(BR);
    cur = 3;
    chk("cursor3", CURSOR_COLOR, 3);
    sel_hold = 10;
    exp_q.push_back('{1'b0, 3});
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #2 BTN_SEL = ~BTN_SEL;
      repeat (2) @(posedge clk);
    end
    #2 BTN_SEL = 1'b1;
    t0 = cyc;
    n = 0;
    while (!COLOR_SEL_SIG && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bounce_req_seen", COLOR_SEL_SIG, 1);
    chk("bounce_latency", cyc - t0, 7);
    r = cyc;
    chk("hs_selected_req", COLOR_SELECTED, 3);
    @(negedge clk);
    chk("hs_sig_held", COLOR_SEL_SIG, 1);
    chk("hs_cc_up", CHANGING_COLOR, 1);
    @(negedge clk);
    chk("hs_sig_fall", COLOR_SEL_SIG, 0);
    chk("hs_selected_wait", COLOR_SELECTED, 3);
    repeat (9) @(negedge clk);
    chk("hs_cc_down", CHANGING_COLOR, 0);
    chk("hs_moves_before", MOVE_COUNT, 0);
    @(negedge clk);
    chk("hs_moves_after", MOVE_COUNT, 1);
    chk("hs_busy_low", BUSY, 0);
    moves = 1;
    tl = 3;
    @(posedge clk);
    #2 BTN_SEL = 1'b0;
    repeat (8) @(posedge clk);
    wait_idle();
    press(BL);
    cur = 2;
    TOP_LEFT_COLOR = 3'd2;
    tl = 2;
    n0 = n_sel;
    press(BS);
    wait_idle();
    chk("same_color_no_req", n_sel - n0, 0);
    chk("same_color_moves", MOVE_COUNT, 1);
    TOP_LEFT_COLOR = 3'd0;
    tl = 0;
    sel_hold = 30;
    exp_q.push_back('{1'b0, 2});
    press(BS);
    press(BS);
    wait_idle();
    moves = 2;
    tl = 2;
    chk("busy_discard_reqs", n_sel - n0, 1);
    chk("busy_discard_moves", MOVE_COUNT, 2);
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 4);
      sel_hold = $urandom_range(1, 6);
      ack_hold = $urandom_range(1, 4);
      case (op)
        0: begin press(BL); cur = (cur + 5) % 6; end
        1: begin press(BR); cur = (cur + 1) % 6; end
        2: press(BL | BR);
        3: begin
          if (cur != tl) begin
            exp_q.push_back('{1'b0, cur});
            moves = (moves == 255) ? 255 : moves + 1;
            tl = cur;
          end
          press(BS);
        end
        default: begin
          exp_q.push_back('{1'b1, 0});
          moves = 0;
          press(BT);
        end
      endcase
      wait_idle();
      chk("rand_cursor", CURSOR_COLOR, cur);
      chk("rand_moves", MOVE_COUNT, moves);
    end
    sel_hold = 1;
    ack_hold = 2;
    while (moves < 255) do_move();
    chk("sat_reach", MOVE_COUNT, 255);
    do_move();
    chk("sat_hold", MOVE_COUNT, 255);
    sel_hold = 30;
    cur = (cur + 1) % 6;
    press(BR);
    exp_q.push_back('{1'b0, cur});
    exp_q.push_back('{1'b1, 0});
    press(BS);
    press(BT);
    n = 0;
    while (BUSY && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("defer_idle", BUSY, 0);
    chk("defer_begin_low", BEGIN_GAME, 0);
    chk("defer_moves_sat", MOVE_COUNT, 255);
    @(negedge clk);
    chk("defer_begin_rise", BEGIN_GAME, 1);
    @(negedge clk);
    chk("defer_ack", ACK_BEGIN_GAME, 1);
    chk("defer_begin_held", BEGIN_GAME, 1);
    chk("defer_moves_held", MOVE_COUNT, 255);
    @(negedge clk);
    chk("defer_begin_fall", BEGIN_GAME, 0);
    chk("defer_moves_clr", MOVE_COUNT, 0);
    wait_idle();
    moves = 0;
    tl = cur;
    sel_hold = 2;
    do_move();
    chk("pre_reset_moves", MOVE_COUNT, 1);
    resp_en = 0;
    cur = (cur + 1) % 6;
    press(BR);
    exp_q.push_back('{1'b0, cur});
    @(posedge clk);
    #2 BTN_SEL = 1'b1;
    n = 0;
    while (!COLOR_SEL_SIG && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("areset_req_up", COLOR_SEL_SIG, 1);
    #3 RESET = 1'b1;
    #1;
    chk("areset_sel_sig", COLOR_SEL_SIG, 0);
    chk("areset_busy", BUSY, 0);
    chk("areset_moves", MOVE_COUNT, 0);
    chk("areset_cursor", CURSOR_COLOR, 0);
    BTN_SEL = 1'b0;
    repeat (3) @(posedge clk);
    #2 RESET = 1'b0;
    repeat (3) @(negedge clk);
    chk("areset_idle", BUSY, 0);
    chk("areset_no_req", COLOR_SEL_SIG, 0);
    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/flood_input_ctrl.md
# flood_input_ctrl

Player-input front end for the Flood-It game. It debounces the four push-buttons and keeps a cursor over the colour palette. It drives the colour-select handshake (COLOR_SEL_SIG / CHANGING_COLOR) and the game-start handshake (BEGIN_GAME / ACK_BEGIN_GAME) into game_logic, and counts completed moves. It is the initiating end of both handshakes that game_logic responds to.

## Interface
Parameters:
- NUM_COLORS, 6: number of palette colours; legal colours are 0..NUM_COLORS-1 (range 2..8).
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised button level must differ from the debounced level before it is accepted (≥2).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- BTN_LEFT  in  1  raw button, asynchronous; moves the cursor down.
- BTN_RIGHT  in  1  raw button, asynchronous; moves the cursor up.
- BTN_SEL  in  1  raw button, asynchronous; commits the cursor colour.
- BTN_START  in  1  raw button, asynchronous; starts a new game.
- TOP_LEFT_COLOR  in  3  current colour of board cell [0][0], from game_logic.
- CHANGING_COLOR  in  1  busy/ack from game_logic for a colour change.
- ACK_BEGIN_GAME  in  1  ack from game_logic for a game start.
- CURSOR_COLOR  out  3  palette colour currently highlighted.
- COLOR_SELECTED  out  3  colour offered to game_logic; stable while COLOR_SEL_SIG=1.
- COLOR_SEL_SIG  out  1  colour-change request.
- BEGIN_GAME  out  1  game-start request.
- MOVE_COUNT  out  8  completed moves this game; saturates at 255.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- Each button is fed through a 2-flop synchroniser and then a debounce counter.
  - The counter clears whenever the synchronised level equals the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A debounced 0→1 transition produces a one-cycle press pulse.
- Cursor:
  - A LEFT pulse decrements CURSOR_COLOR; 0 wraps to NUM_COLORS-1.
  - A RIGHT pulse increments CURSOR_COLOR; NUM_COLORS-1 wraps to 0.
  - If LEFT and RIGHT pulse in the same cycle, the cursor does not change.
  - Cursor moves are accepted in every state.
- FSM states: IDLE, SEL_REQ, SEL_WAIT, START_REQ, START_WAIT.
  - IDLE, START pulse or start_pending=1: go to START_REQ and drive BEGIN_GAME=1. Start has priority over a SEL pulse in the same cycle, and clears start_pending.
  - IDLE, SEL pulse with CURSOR_COLOR≠TOP_LEFT_COLOR: latch COLOR_SELECTED←CURSOR_COLOR, drive COLOR_SEL_SIG=1, go to SEL_REQ.
  - IDLE, SEL pulse with CURSOR_COLOR=TOP_LEFT_COLOR: the pulse is dropped and no move is counted.
  - SEL_REQ: hold COLOR_SEL_SIG=1 and COLOR_SELECTED stable. On sampling CHANGING_COLOR=1, drive COLOR_SEL_SIG=0 and go to SEL_WAIT.
  - SEL_WAIT: on sampling CHANGING_COLOR=0, go to IDLE and MOVE_COUNT←min(MOVE_COUNT+1, 255).
  - START_REQ: hold BEGIN_GAME=1. On sampling ACK_BEGIN_GAME=1, drive BEGIN_GAME=0, set MOVE_COUNT←0 and go to START_WAIT.
  - START_WAIT: on sampling ACK_BEGIN_GAME=0, go to IDLE.
- SEL pulses outside IDLE are discarded; they are never queued.
- A START pulse outside IDLE/START_REQ/START_WAIT sets start_pending. The start is issued once the current transaction returns to IDLE.
- Requests never time out; the FSM waits on game_logic indefinitely.
- COLOR_SEL_SIG and BEGIN_GAME are never high simultaneously.

## Timing
- Values after RESET: all outputs 0, FSM=IDLE, start_pending=0, all debounced levels 0, all debounce counters 0, synchronisers 0.
- RESET may be asserted mid-transaction. It drops any request immediately, because the request outputs are asynchronously cleared.
- All outputs are registered; there is no combinational path from any input to any output.
- Press latency:
  - The raw edge needs 2 cycles through the synchroniser, plus DEBOUNCE_CYCLES cycles of debounce, before the pulse.
  - The request output rises on the clock edge after the pulse.
- Handshake reaction: each CHANGING_COLOR or ACK_BEGIN_GAME transition is acted on at the first clock edge where it is sampled, i.e. one cycle of reaction.
- Against game_logic:
  - COLOR_SEL_SIG stays high for 2 cycles minimum (the request cycle plus the ack cycle).
  - The next SEL can be accepted no earlier than 1 cycle after CHANGING_COLOR falls.

## Test plan
Run with DEBOUNCE_CYCLES=4 and NUM_COLORS=6.
- Bounce rejection: BTN_SEL toggled every 2 cycles for 20 cycles, then held high → exactly one COLOR_SEL_SIG request, rising 2+4+1 cycles after the final stable edge.
- Colour handshake with a model responder: CURSOR_COLOR=3, TOP_LEFT_COLOR=1, SEL press. The responder raises CHANGING_COLOR 1 cycle after the request and lowers it 10 cycles later. Required: COLOR_SELECTED=3 throughout, COLOR_SEL_SIG falls 1 cycle after CHANGING_COLOR rises, MOVE_COUNT 0→1 one cycle after CHANGING_COLOR falls, BUSY low again.
- Same-colour filter and busy discard:
  - SEL press with CURSOR_COLOR=TOP_LEFT_COLOR=2 → no request, MOVE_COUNT unchanged.
  - A second SEL press during SEL_WAIT → ignored, exactly one move counted.
- Cursor wrap: from reset, LEFT → CURSOR_COLOR=5; then RIGHT twice → 1; LEFT and RIGHT in the same cycle → unchanged.
- Start deferred and count saturation:
  - Preload MOVE_COUNT=255 via 255 moves, do one more move → MOVE_COUNT stays 255.
  - START pressed during SEL_WAIT → BEGIN_GAME rises 1 cycle after return to IDLE. The ACK clears MOVE_COUNT to 0 and BEGIN_GAME falls next cycle.
- Async reset mid-request: RESET asserted between clock edges while COLOR_SEL_SIG=1 → COLOR_SEL_SIG, BUSY and MOVE_COUNT read 0 before the next edge, and FSM=IDLE after RESET is released.
